// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters
// and the even-parity helper used by both the receiver and the transmitter.
package uart_pkg;

   localparam int unsigned DEF_NB_DATA = 8;
   localparam int unsigned DEF_SB_TICK = 16;
   localparam int unsigned DEF_OVS     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } uart_state_t;

   // Returns 1 when the word holds an odd number of ones, i.e. the bit that
   // makes the total count even.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// value both flops take during reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: start, NB_DATA bits LSB first, optional
// even parity (build with UART_RX_PARITY_EN) and a SB_TICK-tick stop interval.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned NB_DATA = DEF_NB_DATA,
   parameter int unsigned SB_TICK = DEF_SB_TICK,
   parameter int unsigned OVS     = DEF_OVS
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_rx_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   output logic               o_frame_err,
   output logic               o_parity_err
);

   localparam int unsigned S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
   localparam int unsigned S_W   = $clog2(S_MAX);
   localparam int unsigned N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [S_W-1:0] S_HALF = S_W'(OVS / 2 - 1);
   localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

   uart_state_t        state, state_nxt;
   logic [S_W-1:0]     s, s_nxt;
   logic [N_W-1:0]     n, n_nxt;
   logic [NB_DATA-1:0] b, b_nxt;
   logic [NB_DATA-1:0] data_nxt;
   logic               valid_nxt;
   logic               frame_err_nxt;
   logic               rx_s;

`ifdef UART_RX_PARITY_EN
   logic par_err, par_err_nxt;
   logic parity_err_nxt;
`endif

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_d    (i_rx_data),
      .o_q    (rx_s)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= ST_IDLE;
         s           <= '0;
         n           <= '0;
         b           <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err      <= 1'b0;
         o_parity_err <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         s           <= s_nxt;
         n           <= n_nxt;
         b           <= b_nxt;
         o_data      <= data_nxt;
         o_valid     <= valid_nxt;
         o_frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
         par_err      <= par_err_nxt;
         o_parity_err <= parity_err_nxt;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign o_parity_err = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      s_nxt         = s;
      n_nxt         = n;
      b_nxt         = b;
      data_nxt      = o_data;
      valid_nxt     = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_nxt    = par_err;
      parity_err_nxt = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_nxt = ST_START;
               s_nxt     = '0;
            end
         end
         ST_START: begin
            if (i_tick) begin
               if (s == S_HALF) begin
                  s_nxt     = '0;
                  n_nxt     = '0;
                  state_nxt = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  s_nxt = s + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_nxt = '0;
                  b_nxt = {rx_s, b[NB_DATA-1:1]};
                  n_nxt = n + 1'b1;
                  if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_nxt = ST_PARITY;
`else
                     state_nxt = ST_STOP;
`endif
                  end
               end else begin
                  s_nxt = s + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_nxt       = '0;
                  par_err_nxt = rx_s ^ even_parity(32'(b));
                  state_nxt   = ST_STOP;
               end else begin
                  s_nxt = s + 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (i_tick) begin
               if (s == S_STOP) begin
                  s_nxt = '0;
                  // A bad stop bit outranks a parity mismatch: only the frame error is flagged.
                  if (rx_s) begin
                     data_nxt  = b;
                     state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     valid_nxt      = !par_err;
                     parity_err_nxt = par_err;
`else
                     valid_nxt = 1'b1;
`endif
                  end else begin
                     frame_err_nxt = 1'b1;
                     state_nxt     = ST_WAIT_HIGH;
                  end
               end else begin
                  s_nxt = s + 1'b1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rx_s) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level model (also builds with UART_RX_PARITY_EN).
module tb_uart_rx;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned OVS     = 16;
   localparam int unsigned SB_TICK = 16;
   localparam int unsigned TICK_DIV = 4;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PAR_BITS = 1;
`else
   localparam int unsigned PAR_BITS = 0;
`endif
   localparam int unsigned FRAME_TICKS = OVS * (NB_DATA + 2 + PAR_BITS);

   logic               i_clk = 1'b0;
   logic               i_reset = 1'b0;
   logic               i_tick = 1'b0;
   logic               i_rx_data = 1'b1;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               o_frame_err;
   logic               o_parity_err;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned tdiv = 0;
   int unsigned n_valid = 0;
   int unsigned n_ferr = 0;
   int unsigned n_perr = 0;
   logic [NB_DATA-1:0] vq[$];
   logic [NB_DATA-1:0] exp_data = '0;

   uart_rx #(
      .NB_DATA(NB_DATA),
      .SB_TICK(SB_TICK),
      .OVS    (OVS)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_rx_data   (i_rx_data),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_parity_err(o_parity_err)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      tdiv   <= (tdiv + 1) % TICK_DIV;
      i_tick <= (tdiv == TICK_DIV - 1);
   end

   // Every high sample counts, so a flag held longer than one cycle shows up as an extra pulse.
   always @(negedge i_clk) begin
      if (o_valid) begin
         n_valid <= n_valid + 1;
         vq.push_back(o_data);
      end
      if (o_frame_err)  n_ferr <= n_ferr + 1;
      if (o_parity_err) n_perr <= n_perr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int unsigned cnt);
      repeat (cnt) begin
         @(posedge i_clk);
         while (i_tick !== 1'b1) @(posedge i_clk);
      end
      #1;
   endtask

   // Drives one frame; the line is left at the stop-bit value.
   task automatic send_frame(input logic [NB_DATA-1:0] d, input logic pbit, input logic stop);
      i_rx_data = 1'b0;
      wait_ticks(OVS);
      for (int i = 0; i < NB_DATA; i++) begin
         i_rx_data = d[i];
         wait_ticks(OVS);
      end
      if (PAR_BITS != 0) begin
         i_rx_data = pbit;
         wait_ticks(OVS);
      end
      i_rx_data = stop;
      wait_ticks(SB_TICK);
   endtask

   task automatic run_frame(input string tag, input logic [NB_DATA-1:0] d, input logic pbit,
                            input logic stop);
      int unsigned v0, f0, p0;
      logic perr, exp_v, exp_f, exp_p;
      v0 = n_valid;
      f0 = n_ferr;
      p0 = n_perr;
      send_frame(d, pbit, stop);
      i_rx_data = 1'b1;
      wait_ticks(4);
      perr  = (PAR_BITS != 0) && (pbit != ^d);
      exp_f = !stop;
      exp_v = stop && !perr;
      exp_p = stop && perr;
      if (stop) exp_data = d;
      check({tag, "_valid"}, n_valid - v0, 32'(exp_v));
      check({tag, "_ferr"},  n_ferr - f0,  32'(exp_f));
      check({tag, "_perr"},  n_perr - p0,  32'(exp_p));
      check({tag, "_data"},  32'(o_data),  32'(exp_data));
   endtask

   initial begin
      int unsigned v0, f0, p0;
      logic [NB_DATA-1:0] d;
      logic [31:0] q0, q1;

      repeat (5) @(posedge i_clk);
      #1;
      check("rst_data",  32'(o_data), 32'h0);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_ferr",  32'(o_frame_err), 32'h0);
      check("rst_perr",  32'(o_parity_err), 32'h0);
      i_reset = 1'b1;
      wait_ticks(8);

      run_frame("good_a5", 8'hA5, ^8'hA5, 1'b1);

      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      i_rx_data = 1'b0;
      wait_ticks(4);
      i_rx_data = 1'b1;
      wait_ticks(20);
      check("glitch_flags", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 32'h0);
      check("glitch_data", 32'(o_data), 32'hA5);
      run_frame("after_glitch", 8'h69, ^8'h69, 1'b1);

      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      send_frame(8'h5A, ^8'h5A, 1'b0);
      wait_ticks(3 * FRAME_TICKS);
      check("break_ferr",  n_ferr - f0, 32'h1);
      check("break_valid", n_valid - v0, 32'h0);
      check("break_perr",  n_perr - p0, 32'h0);
      check("break_data",  32'(o_data), 32'(exp_data));
      i_rx_data = 1'b1;
      wait_ticks(8);
      check("break_release_ferr", n_ferr - f0, 32'h1);
      run_frame("after_break", 8'hC3, ^8'hC3, 1'b1);

      vq.delete();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      i_rx_data = 1'b1;
      wait_ticks(8);
      q0 = (vq.size() > 0) ? 32'(vq[0]) : 32'hDEAD;
      q1 = (vq.size() > 1) ? 32'(vq[1]) : 32'hDEAD;
      check("b2b_count", vq.size(), 32'h2);
      check("b2b_first", q0, 32'h00);
      check("b2b_second", q1, 32'hFF);
      exp_data = 8'hFF;

      i_rx_data = 1'b0;
      wait_ticks(OVS);
      for (int i = 0; i < 4; i++) begin
         i_rx_data = i[0];
         wait_ticks(OVS);
      end
      i_reset = 1'b0;
      #1;
      check("midrst_data",  32'(o_data), 32'h0);
      check("midrst_valid", 32'(o_valid), 32'h0);
      check("midrst_ferr",  32'(o_frame_err), 32'h0);
      check("midrst_perr",  32'(o_parity_err), 32'h0);
      exp_data = '0;
      i_rx_data = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      wait_ticks(8);
      check("midrst_hold", 32'(o_data), 32'h0);
      run_frame("after_rst_3c", 8'h3C, ^8'h3C, 1'b1);

`ifdef UART_RX_PARITY_EN
      run_frame("par_good_07", 8'h07, 1'b1, 1'b1);
      run_frame("par_bad_07", 8'h07, 1'b0, 1'b1);
      run_frame("par_bad_ferr", 8'h18, 1'b1, 1'b0);
`endif

      for (int k = 0; k < 24; k++) begin
         d = NB_DATA'($urandom_range(0, 255));
         run_frame("rand", d, (^d) ^ ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 4) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: converts the serial line into parallel words and is the receive-side counterpart of the `tx` transmitter. It runs from the same system clock and uses the same 16x-oversampling `i_tick` from `baud_rate_generator`. Frame format is 1 start bit, NB_DATA data bits sent LSB first, an optional even-parity bit, and a stop interval. Each received word is presented with a one-cycle valid pulse and error flags.

## Interface
- NB_DATA, 8, data bits per frame
- SB_TICK, 16, ticks in the stop interval (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- OVS, 16, ticks per bit period
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_tick  in  1  one-cycle strobe at OVS × baud rate
- i_rx_data  in  1  serial line, asynchronous, idle high
- o_data  out  NB_DATA  last received word, held until the next good frame
- o_valid  out  1  one-cycle pulse when a good frame is received
- o_frame_err  out  1  one-cycle pulse when the stop bit samples low
- o_parity_err  out  1  one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only; tied 0 otherwise)

## Operation
- i_rx_data passes through a 2-flop synchronizer. Its reset value is 1. All FSM decisions use the synchronized bit `rx_s`.
- Counters:
  - `s`: tick counter, wraps at OVS-1 or SB_TICK-1.
  - `n`: bit counter, width clog2(NB_DATA).
  - `b`: NB_DATA-bit right-shift register; the new bit enters at the MSB.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE: when `rx_s`=0, go to START and set s=0. No tick is needed.
  - START: on each tick, s++. At s=OVS/2-1 (mid start bit):
    - `rx_s`=0: go to DATA with s=0, n=0.
    - `rx_s`=1: glitch; return to IDLE with no flags raised.
  - DATA: on each tick, s++. At s=OVS-1, shift `rx_s` into `b`, set s=0, n++. After bit NB_DATA-1, go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: at s=OVS-1, sample the parity bit, set s=0, go to STOP.
  - STOP: on each tick, s++. At s=SB_TICK-1, sample `rx_s`:
    - `rx_s`=1: load o_data←`b`. Pulse o_valid unless there is a parity error. Go to IDLE.
    - `rx_s`=0: pulse o_frame_err, leave o_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This stops a break condition (line held low) from retriggering frames.
- A parity error pulses o_parity_err and suppresses o_valid. o_data is still updated, for debug.
- If both errors occur, o_frame_err takes precedence: neither o_valid nor o_parity_err pulses, and the FSM goes to WAIT_HIGH.
- Ticks outside the START/DATA/PARITY/STOP states are ignored.

## Timing
- Reset values:
  - o_data = 0; o_valid = 0; o_frame_err = 0; o_parity_err = 0.
  - FSM = IDLE; s = 0; n = 0; b = 0; synchronizer = 1.
- All outputs are registered. Flags assert in the cycle after the i_clk edge that sees the final STOP tick, and last exactly 1 cycle.
- Latency from a line falling edge to the IDLE→START transition is 2–3 cycles (synchronizer).
- Data bits are sampled at the middle of each bit period, OVS ticks apart.
- Back-to-back frames are supported: with SB_TICK=16, the next start edge may arrive at the tick right after the stop sample.
- Reset mid-frame: the FSM and all outputs return to reset values immediately, and any partial word is discarded.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present.
  - The frame carries an even-parity bit after the data bits.
  - Expected parity = ^`b`; a mismatch drives o_parity_err.
- UART_RX_PARITY_EN undefined:
  - PARITY state and parity logic are absent.
  - o_parity_err is constant 0.
  - The frame is start + data + stop only.

## Structure
- `uart_pkg` holds:
  - the state encoding constants (ST_IDLE … ST_WAIT_HIGH);
  - default OVS, NB_DATA, SB_TICK;
  - the even-parity function.
- The `tx` block must share the same package.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a reset-value parameter (set to 1 here).

## Test plan
- **Good frame:** send 0xA5 at 16x ticks with a valid stop bit. Expect o_data=0xA5, exactly one o_valid pulse, and o_frame_err=0.
- **Glitch:** hold the line low for 4 ticks, then high. Expect no flags, FSM back in IDLE, and o_data unchanged.
- **Framing error and break:** send 0x5A with stop bit 0, then hold the line low for 3 frame times. Expect one o_frame_err pulse, no o_valid, and no further flags until the line goes high.
- **Back-to-back:** send 0x00 then 0xFF with a single stop bit. Expect two o_valid pulses, with o_data=0x00 and then 0xFF.
- **Reset mid-frame:** assert i_reset after data bit 3. Expect all outputs 0 immediately. A following 0x3C frame is received correctly.
- **Parity (macro defined):**
  - 0x07 with parity bit 1: expect o_valid and o_parity_err=0.
  - 0x07 with parity bit 0: expect o_parity_err pulse, no o_valid, and o_data=0x07.
